// File: rtl/if_id_buf_pkg.sv
// Shared constants for the IF->ID stage buffer: bubble values, hold codes and bus widths.
package if_id_buf_pkg;

  localparam int INST_BUS_W = 32;
  localparam int ADDR_BUS_W = 32;
  localparam int INT_BUS_W  = 8;
  localparam int HOLD_BUS_W = 3;

  localparam logic [INST_BUS_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [ADDR_BUS_W-1:0] ZERO_WORD = '0;
  localparam logic [INT_BUS_W-1:0]  INT_NONE  = '0;

  localparam logic [HOLD_BUS_W-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_BUS_W-1:0] HOLD_IF   = 3'd1;
  localparam logic [HOLD_BUS_W-1:0] HOLD_ID   = 3'd2;
  localparam logic [HOLD_BUS_W-1:0] HOLD_EX   = 3'd3;

  // Hold codes are ordered, so a stage stalls for its own level and every deeper one.
  function automatic logic is_held(input logic [HOLD_BUS_W-1:0] code,
                                   input logic [HOLD_BUS_W-1:0] lvl);
    return code >= lvl;
  endfunction

endpackage

// File: rtl/if_id_buf_fifo.sv
// Generic circular FIFO storage with wrapping pointers, occupancy count and synchronous flush.
module if_id_buf_fifo
  import if_id_buf_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers rely on natural overflow, hence the power-of-two DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_buf.sv
// IF->ID stage buffer: FIFO of fetched entries with hold gating, flush and a NOP bubble when empty.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int                 INST_W       = INST_BUS_W,
  parameter int                 ADDR_W       = ADDR_BUS_W,
  parameter int                 INT_W        = INT_BUS_W,
  parameter int                 DEPTH        = 2,
  parameter int                 HOLD_W       = HOLD_BUS_W,
  parameter logic [HOLD_W-1:0]  HOLD_LVL     = HOLD_IF,
  parameter logic [INST_W-1:0]  NOP_VAL      = INST_NOP,
  parameter logic [INT_W-1:0]   INT_NONE_VAL = INT_NONE,
  localparam int                CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int ENT_W = INST_W + ADDR_W + INT_W;

  logic             hold;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] count;

  assign hold = (hold_flag_i >= HOLD_LVL);

  // No pass-through when full: a pop this cycle only frees the slot for the next one.
  assign in_ready_o  = !rst && !hold && !flush_i && (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0) && !hold;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  if_id_buf_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush_i),
    .wr_data ({inst_i, inst_addr_i, int_flag_i}),
    .rd_data (head),
    .count   (count)
  );

  // Head data stays visible under hold; only out_valid_o is suppressed.
  always_comb begin
    inst_o      = NOP_VAL;
    inst_addr_o = '0;
    int_flag_o  = INT_NONE_VAL;
    if (count != '0) begin
      {inst_o, inst_addr_o, int_flag_o} = head;
    end
  end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised IF→ID stage buffer; successor to the single-register IF/ID stage.
- Holds up to DEPTH fetched {inst, inst_addr, int_flag} entries in a circular FIFO with valid/ready handshakes on both sides.
- Supports a hold level and a synchronous flush for branch/jump/interrupt redirection.
- Sits between the fetch unit (PC + ROM read) and the decoder; empty-state outputs present a NOP bubble.

Parameters:
- INST_W, 32, instruction width
- ADDR_W, 32, instruction address width
- INT_W, 8, interrupt flag width
- DEPTH, 2, entry count; power of two, ≥2
- HOLD_W, 3, hold_flag_i width
- HOLD_LVL, 1, hold code at or above which this stage stalls (matches Hold_If)
- NOP_VAL, 32'h00000013, instruction presented when empty (INST_NOP)
- INT_NONE_VAL, 0, interrupt flag presented when empty

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid_i  in  1  fetch entry valid
- in_ready_o  out  1  buffer accepts entry
- inst_i  in  INST_W  fetched instruction
- inst_addr_i  in  ADDR_W  fetched PC
- int_flag_i  in  INT_W  interrupt flag with fetch
- hold_flag_i  in  HOLD_W  pipeline hold code from ctrl
- flush_i  in  1  discard all entries (redirect)
- out_valid_o  out  1  head entry valid to decode
- out_ready_i  in  1  decode consumes head
- inst_o  out  INST_W  head instruction or NOP_VAL
- inst_addr_o  out  ADDR_W  head address or 0
- int_flag_o  out  INT_W  head flag or INT_NONE_VAL
- count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high. Reset clears wr_ptr, rd_ptr and count to 0.
- Storage arrays are not reset.
- While in reset: out_valid_o=0, inst_o=NOP_VAL, inst_addr_o=0, int_flag_o=INT_NONE_VAL, count_o=0, in_ready_o=0.
- Derived signals:
  - hold = (hold_flag_i >= HOLD_LVL).
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
- in_ready_o = !rst & !hold & !flush_i & (count < DEPTH). Combinational; there is no pass-through when full.
- out_valid_o = (count != 0) & !hold. Combinational.
- Outputs are combinational from the head entry (rd_ptr) when count != 0; otherwise the NOP/0/INT_NONE defaults.
  - During hold the head data remains visible, but out_valid_o=0.
- Latency: an entry pushed at edge N is visible with out_valid_o=1 after edge N (one-cycle latency). Throughput is 1 entry/cycle.
- Push: writes mem[wr_ptr], then wr_ptr++.
- Pop: rd_ptr++.
- Pointers wrap modulo DEPTH (natural overflow of log2(DEPTH)-bit pointers).
- Count update:
  - push & !pop: +1.
  - pop & !push: −1.
  - both or neither: unchanged.
- Flush takes priority over everything. On a flush edge: wr_ptr=rd_ptr=count=0, and no push or pop takes effect.
  - The next cycle presents NOP with out_valid_o=0.
- Hold blocks both push and pop. State is frozen and count_o is stable.
- Flush during hold: flush wins and the buffer empties.
- Full (count==DEPTH): in_ready_o=0. A simultaneous pop frees the slot for the next cycle.
- Empty: pop is impossible because out_valid_o=0.
- count never exceeds DEPTH and never underflows. A bench assertion checks both.

Decomposition:
- Shared package/header: INST_NOP, INT_NONE, Hold_If / hold level codes, ZeroWord, bus-width defines.
- One natural sub-module: if_id_buf_fifo. It holds the generic DEPTH×(INST_W+ADDR_W+INT_W) circular storage with pointers and count, and supports flush.
- The top level adds hold gating, default-value muxing and the handshake.

Test Plan:
- Reset release, idle:
  - Required: out_valid_o=0, inst_o=0x00000013, inst_addr_o=0, int_flag_o=0, count_o=0, in_ready_o=1.
- Single push, out_ready_i=1:
  - Stimulus: push inst=0x00500093, addr=0x100, int=0x00.
  - Required: the next cycle shows out_valid_o=1 with those values; it pops, and the buffer returns to NOP/count 0.
- Fill to full, out_ready_i=0:
  - Stimulus: push 0x100 and 0x104.
  - Required: count_o=2, in_ready_o=0. Raising out_ready_i pops 0x100 then 0x104 in order.
  - Pushing 0x108 during the first pop is accepted on the following cycle, which exercises pointer wrap.
- Hold:
  - Stimulus: hold_flag_i=HOLD_LVL with 1 entry at 0x200.
  - Required: out_valid_o=0, in_ready_o=0, inst_addr_o=0x200 stable, count_o=1 stable.
  - Releasing hold then delivers 0x200.
- Flush:
  - Stimulus: flush_i=1 with 2 entries, in the same cycle as in_valid_i=1 (addr 0x300).
  - Required: next cycle count_o=0, out_valid_o=0, 0x300 not stored. Flush asserted during hold also empties.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst between clock edges with count_o=2.
  - Required: outputs go to reset values immediately, without waiting for an edge. After release the first push appears normally.
